// File: rtl/wb_queue_pkg.sv
// Shared definitions for the write-back queue in front of the register file's
// single write port.
package wb_queue_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Forwarding lookup: finds the youngest occupied queue entry whose address
// matches a read address and returns its data.
module wb_fwd_match
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int width = DATA_W,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_i,
    input  logic [DEPTH-1:0][width-1:0]      data_i,
    input  logic [DEPTH-1:0]                 valid_i,
    input  logic [PTR_W-1:0]                 head_i,
    input  logic [REG_ADDR_W-1:0]            rd_addr_i,
    output logic                             hit_o,
    output logic [width-1:0]                 data_o
);

    // Walk from oldest (head) to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PTR_W-1:0] slot;
        hit_o  = 1'b0;
        data_o = '0;
        slot   = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_i + PTR_W'(k);
            if (valid_i[slot] && (addr_i[slot] == rd_addr_i) && (rd_addr_i != ZERO_REG)) begin
                hit_o  = 1'b1;
                data_o = data_i[slot];
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers register-write requests in order, drains one per
// granted cycle into the register file, and forwards pending data to readers.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int width = DATA_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REG_ADDR_W-1:0]   in_addr,
    input  logic [width-1:0]        in_data,
    input  logic                    drain_en,
    output logic                    wr_enable,
    output logic [REG_ADDR_W-1:0]   W_addr,
    output logic [width-1:0]        W_data,
    input  logic [REG_ADDR_W-1:0]   A_addr,
    input  logic [REG_ADDR_W-1:0]   B_addr,
    output logic                    A_hit,
    output logic                    B_hit,
    output logic [width-1:0]        A_fwd,
    output logic [width-1:0]        B_fwd,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]                 head_q, head_d;
    logic [PTR_W-1:0]                 tail_q, tail_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][width-1:0]      data_q;
    logic [DEPTH-1:0]                 valid;
    logic [PTR_W-1:0]                 offset;
    logic                             empty, push, pop;

    assign empty     = (count_q == '0);
    assign pop       = drain_en && !empty;
    assign in_ready  = (count_q != FULL) || pop;
    // Writes to R0 complete the handshake but are never stored.
    assign push      = in_valid && in_ready && (in_addr != ZERO_REG);
    assign wr_enable = pop;
    assign W_addr    = empty ? '0 : addr_q[head_q];
    assign W_data    = empty ? '0 : data_q[head_q];
    assign count     = count_q;

    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // A slot is occupied when its distance from the head is below the count.
    always_comb begin
        valid  = '0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset   = PTR_W'(i) - head_q;
            valid[i] = ({1'b0, offset} < count_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                addr_q[tail_q] <= in_addr;
                data_q[tail_q] <= in_data;
            end
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH), .width(width), .PTR_W(PTR_W)) u_fwd_a (
        .addr_i    (addr_q),
        .data_i    (data_q),
        .valid_i   (valid),
        .head_i    (head_q),
        .rd_addr_i (A_addr),
        .hit_o     (A_hit),
        .data_o    (A_fwd)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .width(width), .PTR_W(PTR_W)) u_fwd_b (
        .addr_i    (addr_q),
        .data_i    (data_q),
        .valid_i   (valid),
        .head_i    (head_q),
        .rd_addr_i (B_addr),
        .hit_o     (B_hit),
        .data_o    (B_fwd)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: a table of per-cycle vectors plus hand-written
// wrap-around and asynchronous-reset sequences.
module tb_wb_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        drain_en;
    logic        wr_enable;
    logic [4:0]  W_addr;
    logic [31:0] W_data;
    logic [4:0]  A_addr, B_addr;
    logic        A_hit, B_hit;
    logic [31:0] A_fwd, B_fwd;
    logic [2:0]  count;

    int nCompared = 0;
    int nFailed   = 0;

    typedef struct {
        logic        v;
        logic [4:0]  ad;
        logic [31:0] dt;
        logic        dr;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        eRdy;
        logic        eWr;
        logic [4:0]  eWa;
        logic [31:0] eWd;
        logic        eAh;
        logic [31:0] eAf;
        logic        eBh;
        logic [31:0] eBf;
        logic [2:0]  eCnt;
    } vec_t;

    vec_t vecs[$];

    wb_queue #(.DEPTH(4), .width(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .drain_en  (drain_en),
        .wr_enable (wr_enable),
        .W_addr    (W_addr),
        .W_data    (W_data),
        .A_addr    (A_addr),
        .B_addr    (B_addr),
        .A_hit     (A_hit),
        .B_hit     (B_hit),
        .A_fwd     (A_fwd),
        .B_fwd     (B_fwd),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
    task automatic applyStimulus(input logic v, input logic [4:0] ad, input logic [31:0] dt,
                                 input logic dr, input logic [4:0] ra, input logic [4:0] rb);
        @(posedge clock);
        #1;
        in_valid = v;
        in_addr  = ad;
        in_data  = dt;
        drain_en = dr;
        A_addr   = ra;
        B_addr   = rb;
    endtask

    task automatic addVec(input logic v, input logic [4:0] ad, input logic [31:0] dt, input logic dr,
                          input logic [4:0] ra, input logic [4:0] rb,
                          input logic eRdy, input logic eWr, input logic [4:0] eWa, input logic [31:0] eWd,
                          input logic eAh, input logic [31:0] eAf, input logic eBh, input logic [31:0] eBf,
                          input logic [2:0] eCnt);
        vec_t t;
        t = '{v, ad, dt, dr, ra, rb, eRdy, eWr, eWa, eWd, eAh, eAf, eBh, eBf, eCnt};
        vecs.push_back(t);
    endtask

    task automatic checkVec(input vec_t t, input int i);
        checkOutput($sformatf("v%0d.in_ready", i),  32'(in_ready),  32'(t.eRdy));
        checkOutput($sformatf("v%0d.wr_enable", i), 32'(wr_enable), 32'(t.eWr));
        checkOutput($sformatf("v%0d.W_addr", i),    32'(W_addr),    32'(t.eWa));
        checkOutput($sformatf("v%0d.W_data", i),    W_data,         t.eWd);
        checkOutput($sformatf("v%0d.A_hit", i),     32'(A_hit),     32'(t.eAh));
        checkOutput($sformatf("v%0d.A_fwd", i),     A_fwd,          t.eAf);
        checkOutput($sformatf("v%0d.B_hit", i),     32'(B_hit),     32'(t.eBh));
        checkOutput($sformatf("v%0d.B_fwd", i),     B_fwd,          t.eBf);
        checkOutput($sformatf("v%0d.count", i),     32'(count),     32'(t.eCnt));
    endtask

    initial begin
        //      v  ad  data     dr  A  B   rdy wr Wa Wd       Ah Af       Bh Bf       cnt
        addVec(0, 0, 0,        0,  5, 0,  1,  0, 0, 0,       0, 0,       0, 0,       0);
        addVec(1, 5, 'h1234,   1,  5, 0,  1,  0, 0, 0,       0, 0,       0, 0,       0);
        addVec(0, 0, 0,        1,  5, 5,  1,  1, 5, 'h1234,  1, 'h1234,  1, 'h1234,  1);
        addVec(0, 0, 0,        1,  5, 0,  1,  0, 0, 0,       0, 0,       0, 0,       0);
        addVec(1, 7, 'hA,      0,  7, 0,  1,  0, 0, 0,       0, 0,       0, 0,       0);
        addVec(1, 7, 'hB,      0,  7, 7,  1,  0, 7, 'hA,     1, 'hA,     1, 'hA,     1);
        addVec(0, 0, 0,        0,  7, 3,  1,  0, 7, 'hA,     1, 'hB,     0, 0,       2);
        addVec(0, 0, 0,        1,  7, 0,  1,  1, 7, 'hA,     1, 'hB,     0, 0,       2);
        addVec(0, 0, 0,        1,  7, 0,  1,  1, 7, 'hB,     1, 'hB,     0, 0,       1);
        addVec(1, 0, 'hFFFF,   1,  0, 7,  1,  0, 0, 0,       0, 0,       0, 0,       0);
        addVec(0, 0, 0,        1,  0, 0,  1,  0, 0, 0,       0, 0,       0, 0,       0);
        addVec(1, 1, 'h11,     0,  1, 0,  1,  0, 0, 0,       0, 0,       0, 0,       0);
        addVec(1, 2, 'h22,     0,  1, 2,  1,  0, 1, 'h11,    1, 'h11,    0, 0,       1);
        addVec(1, 3, 'h33,     0,  2, 3,  1,  0, 1, 'h11,    1, 'h22,    0, 0,       2);
        addVec(1, 4, 'h44,     0,  3, 4,  1,  0, 1, 'h11,    1, 'h33,    0, 0,       3);
        addVec(1, 5, 'h55,     0,  4, 1,  0,  0, 1, 'h11,    1, 'h44,    1, 'h11,    4);
        addVec(1, 5, 'h55,     0,  4, 1,  0,  0, 1, 'h11,    1, 'h44,    1, 'h11,    4);
        addVec(1, 5, 'h55,     1,  5, 1,  1,  1, 1, 'h11,    0, 0,       1, 'h11,    4);
        addVec(0, 0, 0,        1,  5, 2,  1,  1, 2, 'h22,    1, 'h55,    1, 'h22,    4);
        addVec(0, 0, 0,        1,  2, 3,  1,  1, 3, 'h33,    0, 0,       1, 'h33,    3);
        addVec(0, 0, 0,        1,  4, 5,  1,  1, 4, 'h44,    1, 'h44,    1, 'h55,    2);
        addVec(0, 0, 0,        1,  4, 5,  1,  1, 5, 'h55,    0, 0,       1, 'h55,    1);
        addVec(0, 0, 0,        1,  4, 5,  1,  0, 0, 0,       0, 0,       0, 0,       0);

        reset    = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        drain_en = 1'b1;
        A_addr   = 5'd5;
        B_addr   = 5'd0;
        #2;
        checkOutput("rst.in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst.wr_enable", 32'(wr_enable), 32'd0);
        checkOutput("rst.W_addr",    32'(W_addr),    32'd0);
        checkOutput("rst.W_data",    W_data,         32'd0);
        checkOutput("rst.A_hit",     32'(A_hit),     32'd0);
        checkOutput("rst.count",     32'(count),     32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].ad, vecs[i].dt, vecs[i].dr, vecs[i].ra, vecs[i].rb);
            #3;
            checkVec(vecs[i], i);
        end

        // Ten back-to-back push/pop pairs: each write must emerge one cycle later.
        for (int i = 0; i <= 10; i++) begin
            logic [4:0] nextAddr, prevAddr;
            nextAddr = 5'(i % 7 + 1);
            prevAddr = 5'((i + 6) % 7 + 1);
            applyStimulus(i < 10, nextAddr, 32'h100 + 32'(i), 1'b1, prevAddr, 5'd0);
            #3;
            if (i == 0) begin
                checkOutput("wrap0.wr_enable", 32'(wr_enable), 32'd0);
                checkOutput("wrap0.count",     32'(count),     32'd0);
            end else begin
                checkOutput($sformatf("wrap%0d.wr_enable", i), 32'(wr_enable), 32'd1);
                checkOutput($sformatf("wrap%0d.W_addr", i),    32'(W_addr),    32'(prevAddr));
                checkOutput($sformatf("wrap%0d.W_data", i),    W_data,         32'h100 + 32'(i - 1));
                checkOutput($sformatf("wrap%0d.A_fwd", i),     A_fwd,          32'h100 + 32'(i - 1));
                checkOutput($sformatf("wrap%0d.count", i),     32'(count),     32'd1);
            end
        end

        // Three pending entries, then an asynchronous reset in mid-cycle.
        applyStimulus(1'b1, 5'd9,  32'hC1, 1'b0, 5'd9, 5'd10);
        applyStimulus(1'b1, 5'd10, 32'hC2, 1'b0, 5'd9, 5'd10);
        applyStimulus(1'b1, 5'd11, 32'hC3, 1'b0, 5'd9, 5'd10);
        applyStimulus(1'b0, 5'd0,  32'h0,  1'b1, 5'd9, 5'd10);
        #1;
        checkOutput("prerst.count", 32'(count), 32'd3);
        checkOutput("prerst.A_hit", 32'(A_hit), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("arst.count",     32'(count),     32'd0);
        checkOutput("arst.wr_enable", 32'(wr_enable), 32'd0);
        checkOutput("arst.W_addr",    32'(W_addr),    32'd0);
        checkOutput("arst.W_data",    W_data,         32'd0);
        checkOutput("arst.A_hit",     32'(A_hit),     32'd0);
        checkOutput("arst.B_hit",     32'(B_hit),     32'd0);
        checkOutput("arst.A_fwd",     A_fwd,          32'd0);
        checkOutput("arst.in_ready",  32'(in_ready),  32'd1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd11);
            #3;
            checkOutput($sformatf("postrst%0d.wr_enable", i), 32'(wr_enable), 32'd0);
            checkOutput($sformatf("postrst%0d.count", i),     32'(count),     32'd0);
            checkOutput($sformatf("postrst%0d.A_hit", i),     32'(A_hit),     32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
